ram_arbiter: RTL and testbench

- Two-port arbiter that shares one single-port block RAM between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write).
- Sits between the core's fetch and memory stages and the RAM instance. Grants at most one access per cycle and registers the read data back to the winning requester.
- Default policy is D-priority. A starvation counter forces an I grant after a bounded number of consecutive I losses.

---
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the RAM.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    i_gnt;
    logic                    i_rvalid;
    logic [DATA_WIDTH-1:0]   i_rdata;

    logic                    d_req;
    logic [DATA_WIDTH/8-1:0] d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic                    d_gnt;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;

    logic                    ram_en;
    logic [DATA_WIDTH/8-1:0] ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch (I) and load/store (D).
// D wins by default; a starvation counter hands I the port after MAX_STARVE losses.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;

    localparam logic [0:0] PRIO_D = 1'b0;
    localparam logic [0:0] PRIO_I = 1'b1;

    localparam logic [4:0] MAX_S = 5'(MAX_STARVE);

    logic [0:0] prio;
    logic [3:0] starve_cnt;
    logic [4:0] starve_inc;
    logic       i_gnt;
    logic       d_gnt;
    logic       i_lose;

    assign starve_inc = {1'b0, starve_cnt} + 5'd1;
    assign i_lose     = bus.i_req && !i_gnt;

    // Pick at most one winner; nothing is granted while reset is held.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (bus.i_req && (!bus.d_req || prio == PRIO_I))
                i_gnt = 1'b1;
            else if (bus.d_req)
                d_gnt = 1'b1;
        end
    end

    assign bus.i_gnt = i_gnt;
    assign bus.d_gnt = d_gnt;

    // Steer the winner onto the RAM; idle cycles drive all zeros.
    always_comb begin
        bus.ram_en    = i_gnt | d_gnt;
        bus.ram_we    = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (d_gnt) begin
            bus.ram_we    = bus.d_we;
            bus.ram_addr  = bus.d_addr;
            bus.ram_wdata = bus.d_wdata;
        end else if (i_gnt) begin
            bus.ram_addr  = bus.i_addr;
        end
    end

    // Count consecutive cycles where I asks and loses, saturating at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (i_lose)
            starve_cnt <= (starve_cnt == 4'hF) ? 4'hF : starve_inc[3:0];
        else
            starve_cnt <= '0;
    end

    // Flip priority to I once starved, back to D after I is served or gives up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= PRIO_D;
        else if (prio == PRIO_D) begin
            if (i_lose && starve_inc >= MAX_S)
                prio <= PRIO_I;
        end else begin
            if (i_gnt || !bus.i_req)
                prio <= PRIO_D;
        end
    end

    // Fetch response: one-cycle pulse, data held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
        end else begin
            bus.i_rvalid <= bus.i_req && i_gnt;
            if (bus.i_req && i_gnt)
                bus.i_rdata <= bus.ram_rdata;
        end
    end

    // Load/store response: writes return the pre-write word as acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.d_rvalid <= bus.d_req && d_gnt;
            if (bus.d_req && d_gnt)
                bus.d_rdata <= bus.ram_rdata;
        end
    end

    if (NB * 8 != DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM.
// Inputs change 1ns after posedge; grants sampled at negedge, responses 1ns after posedge.
module tb_ram_arbiter;
    localparam logic [0:0] PRIO_D = 1'b0;
    localparam logic [0:0] PRIO_I = 1'b1;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [4096];

    ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    ram_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12),
        .MAX_STARVE(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_rdata = mem[bus.ram_addr];

    // RAM model: byte-enabled write at the clock edge; preload port for the bench.
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (bus.ram_en)
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b])
                    mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(posedge clk);
        #1;
        pre_en   = 1'b0;
    endtask

    task automatic test_reset;
        bus.i_req  = 1'b1;
        bus.i_addr = 12'h001;
        bus.d_req  = 1'b1;
        bus.d_addr = 12'h002;
        bus.d_we   = 4'b0000;
        @(posedge clk);
        #1;
        tests++;
        if (bus.d_rvalid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_d_rvalid got=%b exp=1", bus.d_rvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.i_gnt, bus.d_gnt, bus.ram_en} !== 3'b000) begin
            fails++;
            $display("FAIL reset_gnt got=%b exp=000",
                     {bus.i_gnt, bus.d_gnt, bus.ram_en});
        end
        tests++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00 ||
            dut.starve_cnt !== 4'd0 || bus.ram_addr !== 12'h000) begin
            fails++;
            $display("FAIL reset_state got=%b cnt=%0d addr=%h exp=00 0 000",
                     {bus.i_rvalid, bus.d_rvalid}, dut.starve_cnt, bus.ram_addr);
        end
        @(posedge clk);
        #1;
        bus.d_req  = 1'b0;
        bus.i_addr = 12'h005;
        rst_n      = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.i_gnt !== 1'b1 || bus.ram_addr !== 12'h005) begin
            fails++;
            $display("FAIL reset_first_gnt got=%b addr=%h exp=1 005",
                     bus.i_gnt, bus.ram_addr);
        end
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        tests++;
        if (bus.i_rvalid !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_rvalid got=%b exp=1", bus.i_rvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read;
        preload(12'h010, 32'hDEADBEEF);
        bus.i_req  = 1'b1;
        bus.i_addr = 12'h010;
        @(negedge clk);
        tests++;
        if (bus.i_gnt !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_we !== 4'b0000) begin
            fails++;
            $display("FAIL iread_gnt got=%b%b%b exp=1 1 0000",
                     bus.i_gnt, bus.ram_en, bus.ram_we);
        end
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        tests++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL iread_resp got=%b %h exp=1 deadbeef",
                     bus.i_rvalid, bus.i_rdata);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL iread_pulse got=%b %h exp=0 deadbeef",
                     bus.i_rvalid, bus.i_rdata);
        end
    endtask

    task automatic test_partial_write;
        preload(12'h020, 32'h11223344);
        bus.d_req   = 1'b1;
        bus.d_addr  = 12'h020;
        bus.d_we    = 4'b0011;
        bus.d_wdata = 32'hAABBCCDD;
        @(negedge clk);
        tests++;
        if (bus.d_gnt !== 1'b1 || bus.ram_we !== 4'b0011 ||
            bus.ram_wdata !== 32'hAABBCCDD) begin
            fails++;
            $display("FAIL dwrite_gnt got=%b %b %h exp=1 0011 aabbccdd",
                     bus.d_gnt, bus.ram_we, bus.ram_wdata);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h11223344) begin
            fails++;
            $display("FAIL dwrite_resp got=%b %h exp=1 11223344",
                     bus.d_rvalid, bus.d_rdata);
        end
        bus.d_we = 4'b0000;
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        tests++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1122CCDD) begin
            fails++;
            $display("FAIL dread_resp got=%b %h exp=1 1122ccdd",
                     bus.d_rvalid, bus.d_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention;
        logic exp_i;
        bus.i_req  = 1'b1;
        bus.i_addr = 12'h030;
        bus.d_req  = 1'b1;
        bus.d_addr = 12'h031;
        bus.d_we   = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            exp_i = (k % 5 == 4);
            @(negedge clk);
            tests++;
            if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
                fails++;
                $display("FAIL contention_%0d got=i%b d%b exp=i%b d%b",
                         k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i);
            end
            @(posedge clk);
            #1;
            if (k == 3) begin
                tests++;
                if (dut.prio !== PRIO_I || dut.starve_cnt !== 4'd4) begin
                    fails++;
                    $display("FAIL contention_prio got=%b cnt=%0d exp=1 4",
                             dut.prio, dut.starve_cnt);
                end
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++)
            preload(12'(k), 32'(k));
        bus.i_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_addr = 12'(k);
            @(posedge clk);
            #1;
            if (k == 3)
                bus.i_req = 1'b0;
            tests++;
            if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'(k)) begin
                fails++;
                $display("FAIL stream_%0d got=%b %h exp=1 %h",
                         k, bus.i_rvalid, bus.i_rdata, 32'(k));
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.i_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL stream_end got=%b exp=0", bus.i_rvalid);
        end
    endtask

    task automatic test_withdrawal;
        bus.i_req  = 1'b1;
        bus.i_addr = 12'h040;
        bus.d_req  = 1'b1;
        bus.d_addr = 12'h041;
        bus.d_we   = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (bus.i_rvalid !== 1'b0 || dut.starve_cnt !== 4'(k + 1)) begin
                fails++;
                $display("FAIL withdraw_%0d got=%b cnt=%0d exp=0 %0d",
                         k, bus.i_rvalid, dut.starve_cnt, k + 1);
            end
        end
        bus.i_req = 1'b0;
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        tests++;
        if (bus.i_rvalid !== 1'b0 || dut.starve_cnt !== 4'd0 ||
            dut.prio !== PRIO_D) begin
            fails++;
            $display("FAIL withdraw_end got=%b cnt=%0d prio=%b exp=0 0 0",
                     bus.i_rvalid, dut.starve_cnt, dut.prio);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.i_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL withdraw_rvalid got=%b exp=0", bus.i_rvalid);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        pre_en      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_partial_write();
        test_contention();
        test_back_to_back();
        test_withdrawal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
